systolic_seq_ctrl: RTL and testbench
====================================

Name: systolic_seq_ctrl

Overview:
- Sequencer for the 16x16 systolic multiply array. It owns the array's control inputs: alu_start, cycle_num, matrix_index and the accumulator clear.
- One start pulse triggers a full matrix multiply:
  - clear the accumulators;
  - stream pre-skewed weight and data rows from the operand SRAMs;
  - zero-flush the queues;
  - write the N result rows to the output SRAM, with backpressure.
- Sits between the TPU command decoder and the array/SRAM datapath.

Parameters:
- ARRAY_SIZE, 16, array dimension N. Legal range 2..32, so that 3N-1 ≤ 511.
- ADDR_W, 10, SRAM address width for the operand and output SRAMs.
- CNT_W, 9, width of cycle_num. Must equal the array's cycle_num width.
- IDX_W, 5, width of matrix_index. Must hold N-1.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- start  in  1  one-cycle command pulse; sampled only in IDLE
- w_base  in  ADDR_W  weight SRAM base address; latched at start
- d_base  in  ADDR_W  data SRAM base address; latched at start
- o_base  in  ADDR_W  output SRAM base address; latched at start
- busy  out  1  high from the cycle after start acceptance until DONE inclusive
- done  out  1  one-cycle completion pulse
- acc_clr_n  out  1  active-low accumulator/queue clear to the array; ANDed with rst_n in the datapath
- sram_ren  out  1  operand SRAM read enable (weight and data read together)
- sram_raddr_w  out  ADDR_W  weight read address
- sram_raddr_d  out  ADDR_W  data read address
- feed_zero  out  1  datapath muxes zeros onto the array operand inputs
- alu_start  out  1  array shift/accumulate enable
- cycle_num  out  CNT_W  array compute cycle index
- matrix_index  out  IDX_W  result row select
- sram_wen_o  out  1  output SRAM write request
- sram_wready_o  in  1  output SRAM accepts the write this cycle
- sram_waddr_o  out  ADDR_W  output write address

Behaviour:
- Reset values: all outputs 0, except acc_clr_n=1. State is IDLE. Counters and latched bases are 0.
- Reset mid-operation: immediate return to IDLE with the reset values above. No write is issued in the reset cycle.
- Operand SRAM read latency is 1 cycle. Memory holds 2N-1 pre-skewed rows per operand, at base+0 .. base+2N-2.
- IDLE:
  - On start=1: latch the three bases, go to CLEAR.
  - start in any other state is ignored. No queueing.
- CLEAR (1 cycle): acc_clr_n=0. Next state PRIME.
- PRIME (1 cycle):
  - sram_ren=1; addresses are w_base+0 and d_base+0.
  - Next state FEED, with k=0.
- FEED (k = 0 .. 3N-2, i.e. 3N-1 cycles):
  - alu_start=1 and cycle_num=k.
  - sram_ren=1 with addresses base+k+1 while k ≤ 2N-3; otherwise sram_ren=0 and the addresses hold their last value.
  - feed_zero=1 for k ≥ 2N-1.
  - Leaving FEED at k=3N-2: go to WRITE with r=0.
- WRITE (r = 0 .. N-1):
  - matrix_index=r, sram_wen_o=1, sram_waddr_o=o_base+r.
  - r advances only when sram_wready_o=1 in the same cycle. The request holds stable while sram_wready_o=0, for unbounded stall.
  - Accepted write of r=N-1 moves the state to DONE.
- DONE (1 cycle): done=1, busy=1. Next state IDLE.
- Outside FEED: alu_start=0 and cycle_num=0. Because the queues are zero after the flush, accumulators stay stable during WRITE.
- Outside WRITE: sram_wen_o=0 and matrix_index=0.
- Address arithmetic is modulo 2^ADDR_W; wrap-around is silent.
- Latency with no stall, start accepted at cycle 0:
  - CLEAR at cycle 1, PRIME at cycle 2;
  - FEED at cycles 3 .. 3N+1;
  - WRITE at cycles 3N+2 .. 4N+1;
  - DONE at cycle 4N+2.
  - For N=16 that is 66 cycles.
- done and start in the same cycle: done is in DONE state, so start is ignored. A new start is accepted only in IDLE, the cycle after done.

Decomposition:
- Package systolic_pkg holds:
  - the state enum (IDLE, CLEAR, PRIME, FEED, WRITE, DONE);
  - localparams FEED_LEN=3N-1, READ_ROWS=2N-1, ZERO_FROM=2N-1.
- No sub-module. One FSM plus two counters (k of CNT_W bits, r of IDX_W bits) in a single module.

Test Plan (N=16, sram_wready_o tied to 1 unless stated):
- Basic run: start with w_base=0x000, d_base=0x040, o_base=0x080.
  - acc_clr_n low at cycle 1.
  - Reads 0x000..0x01E and 0x040..0x05E at cycles 2..32.
  - alu_start high at cycles 3..49 with cycle_num 0..46; feed_zero high at cycles 34..49.
  - Writes 0x080..0x08F with matrix_index 0..15 at cycles 50..65.
  - done at cycle 66; busy high at cycles 1..66.
- Functional: identity weights times a counting data matrix, with the real array attached → output SRAM rows equal the data rows. Second back-to-back run gives the same result, proving the clear works.
- Backpressure: sram_wready_o=0 for 5 cycles at r=3 → waddr 0x083 and matrix_index 3 held stable, no skipped row, done at cycle 71.
- Ignored start: pulse start during FEED and during DONE → no restart, bases unchanged, single done pulse.
- Mid-op reset: rst_n low at cycle 20 for 1 cycle → all outputs at reset values the next cycle. A new start then completes normally in 66 cycles.
- Address wrap: d_base=0x3F0 → read addresses wrap 0x3FF→0x000, ending at 0x00E.

Source files
------------

// File: rtl/systolic_pkg.sv
// Shared types and sequence-length helpers for the systolic array sequencer.
package systolic_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_PRIME = 3'd2,
    ST_FEED  = 3'd3,
    ST_WRITE = 3'd4,
    ST_DONE  = 3'd5
  } state_e;

  localparam int unsigned ARRAY_SIZE_DEF = 16;
  localparam int unsigned FEED_LEN       = 3 * ARRAY_SIZE_DEF - 1;
  localparam int unsigned READ_ROWS      = 2 * ARRAY_SIZE_DEF - 1;
  localparam int unsigned ZERO_FROM      = 2 * ARRAY_SIZE_DEF - 1;

  // Same quantities for an arbitrary array dimension n.
  function automatic int unsigned feed_len(input int unsigned n);
    return 3 * n - 1;
  endfunction

  function automatic int unsigned read_rows(input int unsigned n);
    return 2 * n - 1;
  endfunction

  function automatic int unsigned zero_from(input int unsigned n);
    return 2 * n - 1;
  endfunction

endpackage

// File: rtl/systolic_seq_ctrl.sv
// Sequencer for the NxN systolic multiply array: clear, prime, feed/flush,
// then write the N result rows to the output SRAM under backpressure.
module systolic_seq_ctrl
  import systolic_pkg::*;
#(
  parameter int unsigned ARRAY_SIZE = 16,
  parameter int unsigned ADDR_W     = 10,
  parameter int unsigned CNT_W      = 9,
  parameter int unsigned IDX_W      = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] w_base,
  input  logic [ADDR_W-1:0] d_base,
  input  logic [ADDR_W-1:0] o_base,
  output logic              busy,
  output logic              done,
  output logic              acc_clr_n,
  output logic              sram_ren,
  output logic [ADDR_W-1:0] sram_raddr_w,
  output logic [ADDR_W-1:0] sram_raddr_d,
  output logic              feed_zero,
  output logic              alu_start,
  output logic [CNT_W-1:0]  cycle_num,
  output logic [IDX_W-1:0]  matrix_index,
  output logic              sram_wen_o,
  input  logic              sram_wready_o,
  output logic [ADDR_W-1:0] sram_waddr_o
);

  localparam logic [CNT_W-1:0] K_LAST    = CNT_W'(feed_len(ARRAY_SIZE) - 1);
  localparam logic [CNT_W-1:0] K_RD_LAST = CNT_W'(read_rows(ARRAY_SIZE) - 2);
  localparam logic [CNT_W-1:0] K_ZERO    = CNT_W'(zero_from(ARRAY_SIZE));
  localparam logic [IDX_W-1:0] R_LAST    = IDX_W'(ARRAY_SIZE - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  k_q, k_d;
  logic [IDX_W-1:0]  r_q, r_d;
  logic [ADDR_W-1:0] raddr_w_q, raddr_w_d;
  logic [ADDR_W-1:0] raddr_d_q, raddr_d_d;
  logic [ADDR_W-1:0] o_base_q, o_base_d;

  // Read address registers double as the latched operand bases: loaded at
  // start, stepped from PRIME, and frozen once the last row has been issued.
  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    r_d       = r_q;
    raddr_w_d = raddr_w_q;
    raddr_d_d = raddr_d_q;
    o_base_d  = o_base_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d   = ST_CLEAR;
          raddr_w_d = w_base;
          raddr_d_d = d_base;
          o_base_d  = o_base;
        end
      end
      ST_CLEAR: state_d = ST_PRIME;
      ST_PRIME: begin
        state_d   = ST_FEED;
        k_d       = '0;
        raddr_w_d = raddr_w_q + ADDR_W'(1);
        raddr_d_d = raddr_d_q + ADDR_W'(1);
      end
      ST_FEED: begin
        if (k_q < K_RD_LAST) begin
          raddr_w_d = raddr_w_q + ADDR_W'(1);
          raddr_d_d = raddr_d_q + ADDR_W'(1);
        end
        if (k_q == K_LAST) begin
          state_d = ST_WRITE;
          k_d     = '0;
          r_d     = '0;
        end else begin
          k_d = k_q + CNT_W'(1);
        end
      end
      ST_WRITE: begin
        if (sram_wready_o) begin
          if (r_q == R_LAST) begin
            state_d = ST_DONE;
            r_d     = '0;
          end else begin
            r_d = r_q + IDX_W'(1);
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      k_q       <= '0;
      r_q       <= '0;
      raddr_w_q <= '0;
      raddr_d_q <= '0;
      o_base_q  <= '0;
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      r_q       <= r_d;
      raddr_w_q <= raddr_w_d;
      raddr_d_q <= raddr_d_d;
      o_base_q  <= o_base_d;
    end
  end

  assign busy         = (state_q != ST_IDLE);
  assign done         = (state_q == ST_DONE);
  assign acc_clr_n    = (state_q != ST_CLEAR);
  assign sram_ren     = (state_q == ST_PRIME) || ((state_q == ST_FEED) && (k_q <= K_RD_LAST));
  assign sram_raddr_w = raddr_w_q;
  assign sram_raddr_d = raddr_d_q;
  assign alu_start    = (state_q == ST_FEED);
  assign cycle_num    = (state_q == ST_FEED) ? k_q : '0;
  assign feed_zero    = (state_q == ST_FEED) && (k_q >= K_ZERO);
  assign matrix_index = (state_q == ST_WRITE) ? r_q : '0;
  // Gated by rst_n so a reset landing mid-WRITE never issues a write.
  assign sram_wen_o   = (state_q == ST_WRITE) && rst_n;
  assign sram_waddr_o = (state_q == ST_WRITE) ? (o_base_q + ADDR_W'(r_q)) : '0;

endmodule

// File: tb/tb_systolic_seq_ctrl.sv
// Randomised self-checking bench for systolic_seq_ctrl against a
// cycle-offset reference model of the run schedule.
module tb_systolic_seq_ctrl;

  localparam int unsigned N  = 16;
  localparam int unsigned AW = 10;
  localparam int unsigned CW = 9;
  localparam int unsigned IW = 5;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [AW-1:0] w_base, d_base, o_base;
  logic          busy, done, acc_clr_n, sram_ren, feed_zero, alu_start;
  logic [AW-1:0] sram_raddr_w, sram_raddr_d, sram_waddr_o;
  logic [CW-1:0] cycle_num;
  logic [IW-1:0] matrix_index;
  logic          sram_wen_o, sram_wready_o;

  systolic_seq_ctrl #(
    .ARRAY_SIZE(N),
    .ADDR_W    (AW),
    .CNT_W     (CW),
    .IDX_W     (IW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .w_base       (w_base),
    .d_base       (d_base),
    .o_base       (o_base),
    .busy         (busy),
    .done         (done),
    .acc_clr_n    (acc_clr_n),
    .sram_ren     (sram_ren),
    .sram_raddr_w (sram_raddr_w),
    .sram_raddr_d (sram_raddr_d),
    .feed_zero    (feed_zero),
    .alu_start    (alu_start),
    .cycle_num    (cycle_num),
    .matrix_index (matrix_index),
    .sram_wen_o   (sram_wen_o),
    .sram_wready_o(sram_wready_o),
    .sram_waddr_o (sram_waddr_o)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: cycles since acceptance (1 = clear cycle), rows accepted.
  bit            m_busy = 1'b0;
  bit            m_fin  = 1'b0;
  int            m_t    = 0;
  int            m_row  = 0;
  logic [AW-1:0] m_wb = '0, m_db = '0, m_ob = '0;

  int            cyc     = 0;
  int            n_done  = 0;
  int            done_at = 0;
  logic [AW-1:0] last_rd_d = '0;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=0x%0h exp=0x%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic check_outputs(input logic rn);
    bit            clr = 1'b0, ren = 1'b0, fz = 1'b0, alu = 1'b0, wr = 1'b0, dn = 1'b0;
    int            cn = 0, mi = 0, k = 0;
    logic [AW-1:0] ew = '0, ed = '0, eo = '0;
    if (m_busy) begin
      if (m_fin) dn = 1'b1;
      else if (m_t == 1) clr = 1'b1;
      else if (m_t == 2) begin
        ren = 1'b1; ew = m_wb; ed = m_db;
      end else if (m_t <= 3 * N + 1) begin
        k   = m_t - 3;
        alu = 1'b1;
        cn  = k;
        fz  = (k >= 2 * N - 1);
        if (k <= 2 * N - 3) begin
          ren = 1'b1; ew = m_wb + AW'(k + 1); ed = m_db + AW'(k + 1);
        end
      end else begin
        wr = 1'b1; mi = m_row; eo = m_ob + AW'(m_row);
      end
    end
    chk_eq("busy",         32'(busy),         32'(m_busy));
    chk_eq("done",         32'(done),         32'(dn));
    chk_eq("acc_clr_n",    32'(acc_clr_n),    32'(!clr));
    chk_eq("sram_ren",     32'(sram_ren),     32'(ren));
    if (ren) begin
      chk_eq("raddr_w",    32'(sram_raddr_w), 32'(ew));
      chk_eq("raddr_d",    32'(sram_raddr_d), 32'(ed));
    end
    chk_eq("feed_zero",    32'(feed_zero),    32'(fz));
    chk_eq("alu_start",    32'(alu_start),    32'(alu));
    chk_eq("cycle_num",    32'(cycle_num),    32'(cn));
    chk_eq("sram_wen",     32'(sram_wen_o),   32'(wr && rn));
    chk_eq("matrix_index", 32'(matrix_index), 32'(mi));
    if (wr) chk_eq("waddr", 32'(sram_waddr_o), 32'(eo));
  endtask

  task automatic advance(input logic st, input logic rdy, input logic rn);
    if (!rn) begin
      m_busy = 1'b0; m_fin = 1'b0;
    end else if (!m_busy) begin
      if (st) begin
        m_busy = 1'b1; m_fin = 1'b0; m_t = 1; m_row = 0;
        m_wb = w_base; m_db = d_base; m_ob = o_base;
      end
    end else if (m_fin) begin
      m_busy = 1'b0;
    end else if (m_t >= 3 * N + 2) begin
      if (rdy) begin
        m_row++;
        if (m_row == N) m_fin = 1'b1;
      end
    end else begin
      m_t++;
    end
  endtask

  task automatic tick(input logic st, input logic rdy, input logic rn);
    start = st; sram_wready_o = rdy; rst_n = rn;
    #1;
    check_outputs(rn);
    if (done === 1'b1) begin n_done++; done_at = cyc; end
    if (sram_ren === 1'b1) last_rd_d = sram_raddr_d;
    advance(st, rdy, rn);
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  // mode 0: no stall, 1: 5-cycle stall at row 3, 2: random stall/start,
  // 3: start pulses in FEED and DONE, 4: reset at cycle 20.
  task automatic run_op(input logic [AW-1:0] wb, input logic [AW-1:0] db,
                        input logic [AW-1:0] ob, input int mode, input int exp_lat);
    int   stalls = 0;
    int   t0;
    logic st, rdy, rn;
    w_base = wb; d_base = db; o_base = ob;
    n_done = 0;
    t0     = cyc;
    tick(1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 400 && m_busy; i++) begin
      st = 1'b0; rdy = 1'b1; rn = 1'b1;
      w_base = AW'($urandom); d_base = AW'($urandom); o_base = AW'($urandom);
      case (mode)
        1: if (m_t >= 3 * N + 2 && !m_fin && m_row == 3 && stalls < 5) rdy = 1'b0;
        2: begin
          rdy = ($urandom_range(0, 9) < 7);
          st  = ($urandom_range(0, 7) == 0);
        end
        3: st = (cyc - t0 == 20) || m_fin;
        4: rn = !(cyc - t0 == 20);
        default: ;
      endcase
      if (!rdy && m_busy && !m_fin && m_t >= 3 * N + 2) stalls++;
      tick(st, rdy, rn);
    end
    chk_eq("timeout", 32'(m_busy), 32'd0);
    if (mode == 4) begin
      rst_n = 1'b1; start = 1'b0;
      #1;
      chk_eq("rst_done_count", 32'(n_done),       32'd0);
      chk_eq("rst_raddr_w",    32'(sram_raddr_w), 32'd0);
      chk_eq("rst_raddr_d",    32'(sram_raddr_d), 32'd0);
      chk_eq("rst_waddr",      32'(sram_waddr_o), 32'd0);
    end else begin
      chk_eq("done_count", 32'(n_done), 32'd1);
      chk_eq("latency",    32'(done_at - t0), 32'(exp_lat + stalls));
    end
    repeat (2) tick(1'b0, 1'b1, 1'b1);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; sram_wready_o = 1'b1;
    w_base = '0; d_base = '0; o_base = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);

    // Reset held with start asserted: nothing may be accepted.
    repeat (3) tick(1'b1, 1'b1, 1'b0);
    chk_eq("reset_raddr_w", 32'(sram_raddr_w), 32'd0);
    chk_eq("reset_raddr_d", 32'(sram_raddr_d), 32'd0);
    chk_eq("reset_waddr",   32'(sram_waddr_o), 32'd0);
    repeat (2) tick(1'b0, 1'b1, 1'b1);

    run_op(10'h000, 10'h040, 10'h080, 0, 66);
    run_op(10'h000, 10'h040, 10'h080, 1, 66);
    run_op(10'h100, 10'h140, 10'h180, 3, 66);
    run_op(10'h000, 10'h040, 10'h080, 4, 0);
    run_op(10'h000, 10'h040, 10'h080, 0, 66);

    run_op(10'h010, 10'h3F0, 10'h3F8, 0, 66);
    chk_eq("wrap_last_raddr_d", 32'(last_rd_d), 32'h00E);

    for (int j = 0; j < 6; j++)
      run_op(AW'($urandom), AW'($urandom), AW'($urandom), 2, 4 * N + 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog cyc=%0d got=running exp=finished", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
